sum_tx_sequencer: RTL and testbench

Controller that sequences the operand-capture → 4-bit add → UART transmit datapath. It captures operands A and B from the 4-bit switch bus on active-low button presses, forms the 5-bit sum, and sends the result to the UART transmitter as a 4-byte ASCII frame: two hex digits, CR, LF. It owns the `uart_tx_en`/`uart_tx_busy` handshake with the UART transmitter. It sits between the board I/O and the UART transmitter, in place of free-running direct wiring.

---
 rtl/sum_tx_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_sum_tx_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_tx_sequencer.sv
// sum_tx_sequencer: captures two 4-bit operands from button presses and sends
// their sum to the UART as a four-byte ASCII frame (two hex digits, CR, LF).
module sum_tx_sequencer #(
  parameter bit          AUTO_SEND   = 1'b0,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       save_a_n,
  input  logic       save_b_n,
  input  logic       send_n,
  input  logic [3:0] data_input,
  input  logic       uart_tx_busy,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [4:0] sum,
  output logic       a_valid,
  output logic       b_valid,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [2:0] btnMeta_q, btnSync_q, btnPrev_q;
  logic [2:0] btnEvent;
  logic [1:0] state_q, state_d;
  logic [3:0] opA_q, opA_d, opB_q, opB_d;
  logic       aValid_q, aValid_d, bValid_q, bValid_d;
  logic [4:0] sum_q, snap_q, snap_d, opSum;
  logic       pending_q, pending_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] ackCnt_q, ackCnt_d;
  logic       err_q, err_d, txEn_q, txEn_d;
  logic [7:0] txData_q, txData_d, curByte;
  logic [3:0] hexLow;
  logic       idle, saveAny, startReq, deferReq, start;

  // Button bits are {send, save_b, save_a}; a press is a 1->0 step of the synchronized level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btnMeta_q <= '1;
      btnSync_q <= '1;
      btnPrev_q <= '1;
    end else begin
      btnMeta_q <= {send_n, save_b_n, save_a_n};
      btnSync_q <= btnMeta_q;
      btnPrev_q <= btnSync_q;
    end
  end

  assign btnEvent = btnPrev_q & ~btnSync_q;
  assign idle     = (state_q == IDLE);
  assign opSum    = {1'b0, opA_q} + {1'b0, opB_q};
  assign saveAny  = btnEvent[0] | btnEvent[1];

  // A request that coincides with a capture waits one cycle so it sees the new operands.
  assign startReq = (btnEvent[2] & ~saveAny) | pending_q;
  assign deferReq = (btnEvent[2] & saveAny) | (AUTO_SEND & btnEvent[1]);
  assign start    = idle & startReq & aValid_q & bValid_q;

  always_comb begin
    hexLow = snap_q[3:0];
    case (idx_q)
      2'd0:    curByte = snap_q[4] ? 8'h31 : 8'h30;
      2'd1:    curByte = (hexLow < 4'd10) ? (8'h30 + {4'h0, hexLow})
                                          : (8'h37 + {4'h0, hexLow});
      2'd2:    curByte = 8'h0D;
      default: curByte = 8'h0A;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    aValid_d  = aValid_q;
    bValid_d  = bValid_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    ackCnt_d  = ackCnt_q;
    err_d     = err_q;
    txEn_d    = 1'b0;
    txData_d  = txData_q;
    pending_d = idle & deferReq;

    if (idle && btnEvent[0]) begin
      opA_d    = data_input;
      aValid_d = 1'b1;
    end
    if (idle && btnEvent[1]) begin
      opB_d    = data_input;
      bValid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          err_d   = 1'b0;
          idx_d   = 2'd0;
          snap_d  = opSum;
        end
      end
      LOAD: begin
        if (!uart_tx_busy) begin
          txEn_d   = 1'b1;
          txData_d = curByte;
          ackCnt_d = 8'd0;
          state_d  = ACK;
        end
      end
      ACK: begin
        // A busy rise on the final count still counts as an acknowledge.
        if (uart_tx_busy) begin
          state_d = DONE;
        end else if (ackCnt_q == 8'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          ackCnt_d = ackCnt_q + 8'd1;
        end
      end
      DONE: begin
        if (!uart_tx_busy) begin
          if (idx_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      opA_q     <= 4'h0;
      opB_q     <= 4'h0;
      aValid_q  <= 1'b0;
      bValid_q  <= 1'b0;
      sum_q     <= 5'd0;
      snap_q    <= 5'd0;
      pending_q <= 1'b0;
      idx_q     <= 2'd0;
      ackCnt_q  <= 8'd0;
      err_q     <= 1'b0;
      txEn_q    <= 1'b0;
      txData_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      aValid_q  <= aValid_d;
      bValid_q  <= bValid_d;
      sum_q     <= opSum;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      ackCnt_q  <= ackCnt_d;
      err_q     <= err_d;
      txEn_q    <= txEn_d;
      txData_q  <= txData_d;
    end
  end

  assign uart_tx_en   = txEn_q;
  assign uart_tx_data = txData_q;
  assign op_a         = opA_q;
  assign op_b         = opB_q;
  assign sum          = sum_q;
  assign a_valid      = aValid_q;
  assign b_valid      = bValid_q;
  assign busy         = ~idle;
  assign err          = err_q;

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Self-checking bench for sum_tx_sequencer: table and random frames, ignored
// inputs, ACK timeout, mid-frame reset, and the AUTO_SEND variant.
module tb_sum_tx_sequencer;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SEND   = 2;
  localparam int BTN_AUTO_A = 3;
  localparam int BTN_AUTO_B = 4;
  localparam int TIMEOUT    = 16;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [4:0]  sum;
    logic [31:0] frame;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       saveAN = 1'b1, saveBN = 1'b1, sendN = 1'b1;
  logic [3:0] dataIn = 4'h0;
  logic       uartBusy = 1'b0;
  logic       uartTxEn;
  logic [7:0] uartTxData;
  logic [3:0] opA, opB;
  logic [4:0] sum;
  logic       aValid, bValid, busy, err;

  logic       autoSaveAN = 1'b1, autoSaveBN = 1'b1, autoSendN = 1'b1;
  logic [3:0] autoDataIn = 4'h0;
  logic       autoUartBusy = 1'b0;
  logic       autoTxEn;
  logic [7:0] autoTxData;
  logic [3:0] autoOpA, autoOpB;
  logic [4:0] autoSum;
  logic       autoAValid, autoBValid, autoBusy, autoErr;

  int vectors = 0;
  int miscompares = 0;
  int cycleCount = 0;
  int strobeCycle = 0;
  int busyLeft = 0;
  int autoBusyLeft = 0;
  bit noAck = 1'b0;
  logic prevEn = 1'b0;
  logic [7:0] strobeQ[$];
  logic [7:0] autoQ[$];
  logic [3:0] modelA = 4'h0, modelB = 4'h0;
  vec_t vecTable[6];

  sum_tx_sequencer #(.AUTO_SEND(1'b0), .ACK_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .save_a_n(saveAN), .save_b_n(saveBN),
    .send_n(sendN), .data_input(dataIn), .uart_tx_busy(uartBusy),
    .uart_tx_en(uartTxEn), .uart_tx_data(uartTxData), .op_a(opA), .op_b(opB),
    .sum(sum), .a_valid(aValid), .b_valid(bValid), .busy(busy), .err(err)
  );

  sum_tx_sequencer #(.AUTO_SEND(1'b1), .ACK_TIMEOUT(TIMEOUT)) dutAuto (
    .clk(clk), .reset_n(reset_n), .save_a_n(autoSaveAN), .save_b_n(autoSaveBN),
    .send_n(autoSendN), .data_input(autoDataIn), .uart_tx_busy(autoUartBusy),
    .uart_tx_en(autoTxEn), .uart_tx_data(autoTxData), .op_a(autoOpA), .op_b(autoOpB),
    .sum(autoSum), .a_valid(autoAValid), .b_valid(autoBValid), .busy(autoBusy), .err(autoErr)
  );

  always @(posedge clk) cycleCount++;

  // UART model: busy rises one clock after a strobe and stays up for 10 clocks.
  always @(negedge clk) begin
    if (uartTxEn === 1'b1) begin
      strobeQ.push_back(uartTxData);
      strobeCycle = cycleCount;
      vectors++;
      if (prevEn === 1'b1 || uartBusy === 1'b1) begin
        miscompares++;
        $display("[TB] FAIL strobeProtocol: prevEn=%0b uartBusy=%0b at strobe, required both 0",
                 prevEn, uartBusy);
      end
      if (!noAck) begin
        uartBusy = 1'b1;
        busyLeft = 10;
      end
    end else if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) uartBusy = 1'b0;
    end
    prevEn = uartTxEn;
  end

  always @(negedge clk) begin
    if (autoTxEn === 1'b1) begin
      autoQ.push_back(autoTxData);
      autoUartBusy = 1'b1;
      autoBusyLeft = 10;
    end else if (autoBusyLeft > 0) begin
      autoBusyLeft--;
      if (autoBusyLeft == 0) autoUartBusy = 1'b0;
    end
  end

  function automatic logic [7:0] modelByte(input int a, input int b, input int i);
    string hexDigits = "0123456789ABCDEF";
    int s = a + b;
    case (i)
      0:       return (s >= 16) ? 8'h31 : 8'h30;
      1:       return hexDigits[s % 16];
      2:       return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setButton(input int btn, input logic level);
    case (btn)
      BTN_A:      saveAN = level;
      BTN_B:      saveBN = level;
      BTN_SEND:   sendN = level;
      BTN_AUTO_A: autoSaveAN = level;
      default:    autoSaveBN = level;
    endcase
  endtask

  task automatic applyStimulus(input int btn, input logic [3:0] value);
    @(negedge clk);
    if (btn == BTN_A || btn == BTN_B) dataIn = value;
    if (btn == BTN_AUTO_A || btn == BTN_AUTO_B) autoDataIn = value;
    setButton(btn, 1'b0);
    repeat (4) @(negedge clk);
    setButton(btn, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic waitIdle(input string name, input int budget, input bit useAuto);
    int n = 0;
    while (((useAuto ? autoBusy : busy) !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s.waitIdle: busy still high after %0d cycles, required low", name, budget);
    end
  endtask

  task automatic checkFrame(input string name, input logic [31:0] expFrame, input bit useAuto);
    logic [7:0] got[$];
    logic [7:0] actual;
    if (useAuto) got = autoQ; else got = strobeQ;
    checkOutput({name, ".count"}, got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      actual = (i < got.size()) ? got[i] : 8'hxx;
      checkOutput($sformatf("%s.byte%0d", name, i), actual, expFrame[31 - 8*i -: 8]);
    end
    if (useAuto) autoQ.delete(); else strobeQ.delete();
  endtask

  task automatic runVector(input string name, input logic [3:0] a, input logic [3:0] b,
                           input logic [4:0] expSum, input logic [31:0] expFrame);
    applyStimulus(BTN_A, a);
    applyStimulus(BTN_B, b);
    modelA = a;
    modelB = b;
    checkOutput({name, ".opA"}, opA, a);
    checkOutput({name, ".opB"}, opB, b);
    checkOutput({name, ".sum"}, sum, expSum);
    checkOutput({name, ".valid"}, {aValid, bValid}, 2'b11);
    checkOutput({name, ".noStrobeOnCapture"}, strobeQ.size(), 0);
    applyStimulus(BTN_SEND, 4'h0);
    checkOutput({name, ".busyInFrame"}, busy, 1);
    waitIdle(name, 400, 1'b0);
    checkOutput({name, ".err"}, err, 0);
    checkFrame(name, expFrame, 1'b0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, ".txEn"}, uartTxEn, 0);
    checkOutput({name, ".txData"}, uartTxData, 8'h00);
    checkOutput({name, ".ops"}, {opA, opB}, 8'h00);
    checkOutput({name, ".sum"}, sum, 0);
    checkOutput({name, ".valid"}, {aValid, bValid}, 2'b00);
    checkOutput({name, ".busy"}, busy, 0);
    checkOutput({name, ".err"}, err, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  ra, rb;
    logic [31:0] rf;
    int n;

    vecTable[0] = '{a: 4'h9, b: 4'h7, sum: 5'd16, frame: 32'h31_30_0D_0A};
    vecTable[1] = '{a: 4'hF, b: 4'hF, sum: 5'd30, frame: 32'h31_45_0D_0A};
    vecTable[2] = '{a: 4'h0, b: 4'h0, sum: 5'd0,  frame: 32'h30_30_0D_0A};
    vecTable[3] = '{a: 4'h2, b: 4'h5, sum: 5'd7,  frame: 32'h30_37_0D_0A};
    vecTable[4] = '{a: 4'hA, b: 4'h3, sum: 5'd13, frame: 32'h30_44_0D_0A};
    vecTable[5] = '{a: 4'h6, b: 4'h9, sum: 5'd15, frame: 32'h30_46_0D_0A};

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      runVector($sformatf("table%0d", i), vecTable[i].a, vecTable[i].b, vecTable[i].sum, vecTable[i].frame);

    for (int i = 0; i < 8; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rf = {modelByte(ra, rb, 0), modelByte(ra, rb, 1), modelByte(ra, rb, 2), modelByte(ra, rb, 3)};
      runVector($sformatf("rand%0d", i), ra, rb, 5'(int'(ra) + int'(rb)), rf);
    end

    // Save and send presses during a frame must be ignored.
    applyStimulus(BTN_SEND, 4'h0);
    applyStimulus(BTN_A, 4'h3);
    applyStimulus(BTN_SEND, 4'h0);
    waitIdle("midFrame", 400, 1'b0);
    checkOutput("midFrame.opAFrozen", opA, modelA);
    checkFrame("midFrame", {modelByte(modelA, modelB, 0), modelByte(modelA, modelB, 1),
                            modelByte(modelA, modelB, 2), modelByte(modelA, modelB, 3)}, 1'b0);
    repeat (60) @(negedge clk);
    checkOutput("midFrame.noExtraFrame", strobeQ.size(), 0);

    // Reset asserted while byte1 is in flight.
    applyStimulus(BTN_SEND, 4'h0);
    n = 0;
    while (strobeQ.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midReset.reachedByte1", strobeQ.size(), 2);
    reset_n = 1'b0;
    #1;
    checkResetValues("midReset");
    repeat (10) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("midReset.noFurtherStrobes", strobeQ.size(), 2);
    checkOutput("midReset.idle", busy, 0);
    strobeQ.delete();

    // Only A captured: a send request is dropped silently.
    applyStimulus(BTN_A, 4'h4);
    applyStimulus(BTN_SEND, 4'h0);
    repeat (20) @(negedge clk);
    checkOutput("missingB.noStrobe", strobeQ.size(), 0);
    checkOutput("missingB.busy", busy, 0);
    checkOutput("missingB.err", err, 0);

    // UART never acknowledges: err must rise TIMEOUT clocks after the strobe.
    noAck = 1'b1;
    applyStimulus(BTN_B, 4'h1);
    applyStimulus(BTN_SEND, 4'h0);
    n = 0;
    while (err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout.errRaised", err, 1);
    checkOutput("timeout.latency", cycleCount - strobeCycle, TIMEOUT);
    checkOutput("timeout.idle", busy, 0);
    checkOutput("timeout.oneStrobe", strobeQ.size(), 1);
    checkOutput("timeout.firstByte", (strobeQ.size() > 0) ? strobeQ[0] : 8'hxx, 8'h30);
    strobeQ.delete();
    repeat (10) @(negedge clk);
    checkOutput("timeout.errSticky", err, 1);
    noAck = 1'b0;
    applyStimulus(BTN_SEND, 4'h0);
    checkOutput("timeout.errCleared", err, 0);
    waitIdle("afterTimeout", 400, 1'b0);
    checkFrame("afterTimeout", {modelByte(4, 1, 0), modelByte(4, 1, 1),
                                modelByte(4, 1, 2), modelByte(4, 1, 3)}, 1'b0);

    // AUTO_SEND instance: capturing B starts the frame without a send press.
    applyStimulus(BTN_AUTO_A, 4'h2);
    checkOutput("auto.noFrameAfterA", autoQ.size(), 0);
    applyStimulus(BTN_AUTO_B, 4'h5);
    waitIdle("auto", 400, 1'b1);
    checkOutput("auto.err", autoErr, 0);
    checkFrame("auto", 32'h30_37_0D_0A, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
